// File: rtl/rr_logb_beat_packer_if.sv
// Handshake bundle between the logb word source, the beat packer and the beat sink.
// slave = packer side, master = traffic source/sink side.
interface rr_logb_beat_packer_if #(
    parameter int IN_WIDTH   = 128,
    parameter int BEAT_WIDTH = 512
);
    localparam int LEN_W  = $clog2(IN_WIDTH + 1);
    localparam int FILL_W = $clog2(2 * BEAT_WIDTH + 1);

    logic                  in_valid;
    logic [IN_WIDTH-1:0]   in_data;
    logic [LEN_W-1:0]      in_len;
    logic                  in_ready;
    logic                  flush_req;
    logic                  flush_done;
    logic                  out_valid;
    logic [BEAT_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  out_ready;
    logic [FILL_W-1:0]     fill_bits;
    logic [31:0]           beat_cnt;

    modport slave (
        input  in_valid, in_data, in_len, flush_req, out_ready,
        output in_ready, flush_done, out_valid, out_data, out_last, fill_bits, beat_cnt
    );
    modport master (
        output in_valid, in_data, in_len, flush_req, out_ready,
        input  in_ready, flush_done, out_valid, out_data, out_last, fill_bits, beat_cnt
    );
endinterface

// File: rtl/rr_logb_beat_packer.sv
// Packs variable-length logb words (LSB-first) into fixed-width beats through a
// 2-beat residual buffer, with a flush sequence that emits a zero-padded final beat.
module rr_logb_beat_packer #(
    parameter int IN_WIDTH   = 128,
    parameter int BEAT_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    rr_logb_beat_packer_if.slave  bus
);
    localparam int LEN_W  = $clog2(IN_WIDTH + 1);
    localparam int FILL_W = $clog2(2 * BEAT_WIDTH + 1);
    localparam int BUF_W  = 2 * BEAT_WIDTH;
    localparam logic [FILL_W-1:0] IN_LIM = FILL_W'(BUF_W - IN_WIDTH);
    localparam logic [FILL_W-1:0] BEAT_F = FILL_W'(BEAT_WIDTH);

    if (IN_WIDTH < 1 || IN_WIDTH > BEAT_WIDTH) begin : g_bad_params
        $error("rr_logb_beat_packer: IN_WIDTH must be in 1..BEAT_WIDTH");
    end

    typedef enum logic [1:0] {RUN, FLUSH, DONE} state_e;

    state_e              state_q;
    logic [BUF_W-1:0]    buf_q, buf_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [31:0]         beat_cnt_q;

    logic                in_ready_w, out_valid_w, out_last_w, in_fire, out_fire;
    logic [IN_WIDTH-1:0] len_mask;
    logic [BEAT_WIDTH-1:0] fl_mask;

    // Handshake decode uses registered state only; rst forces the idle view immediately.
    assign in_ready_w  = rst || (state_q == RUN && fill_q <= IN_LIM);
    assign out_valid_w = !rst && ((state_q == RUN && fill_q >= BEAT_F) ||
                                  (state_q == FLUSH && fill_q != '0));
    assign out_last_w  = !rst && state_q == FLUSH && fill_q != '0 && fill_q <= BEAT_F;
    assign in_fire     = bus.in_valid && in_ready_w;
    assign out_fire    = out_valid_w && bus.out_ready;

    always_comb begin
        len_mask = '0;
        fl_mask  = '0;
        for (int i = 0; i < IN_WIDTH; i++)   len_mask[i] = (i < int'(bus.in_len));
        for (int i = 0; i < BEAT_WIDTH; i++) fl_mask[i]  = (i < int'(fill_q));
    end

    // Bits at and above F are kept zero, so insertion can simply OR in the new word.
    always_comb begin
        buf_d  = buf_q;
        fill_d = fill_q;
        if (out_fire) begin
            if (out_last_w) begin
                buf_d  = '0;
                fill_d = '0;
            end else begin
                buf_d  = buf_q >> BEAT_WIDTH;
                fill_d = fill_q - BEAT_F;
            end
        end
        if (in_fire) begin
            buf_d  = buf_d | (BUF_W'(bus.in_data & len_mask) << fill_d);
            fill_d = fill_d + FILL_W'(bus.in_len);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            buf_q      <= '0;
            fill_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
            if (out_fire) beat_cnt_q <= beat_cnt_q + 32'd1;
            case (state_q)
                RUN:     if (bus.flush_req && !in_fire) state_q <= FLUSH;
                FLUSH:   if (fill_q == '0 || (out_fire && out_last_w)) state_q <= DONE;
                DONE:    state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_w;
    assign bus.out_valid  = out_valid_w;
    assign bus.out_last   = out_last_w;
    assign bus.out_data   = (state_q == FLUSH) ? (buf_q[BEAT_WIDTH-1:0] & fl_mask)
                                               : buf_q[BEAT_WIDTH-1:0];
    assign bus.flush_done = !rst && state_q == DONE;
    assign bus.fill_bits  = fill_q;
    assign bus.beat_cnt   = beat_cnt_q;
endmodule

// File: doc/rr_logb_beat_packer.md
RR_LOGB_BEAT_PACKER -- requirements
Module: rr_logb_beat_packer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 128: maximum valid bits per input packed-logb word.
REQ-002 SHALL have parameter BEAT_WIDTH, default 512: fixed output beat width in bits.
REQ-003 SHALL have localparam LEN_W = $clog2(IN_WIDTH+1) and FILL_W = $clog2(2*BEAT_WIDTH+1).
REQ-004 SHALL have one clock and a synchronous active-high reset: clk  input  1  clock, all logic on posedge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  input packed-logb word present.
REQ-007 in_data  input  IN_WIDTH  packed bits, LSB-first; bits at or above in_len ignored.
REQ-008 in_len  input  LEN_W  number of valid bits in in_data, 0..IN_WIDTH.
REQ-009 in_ready  output  1  packer accepts the word this cycle.
REQ-010 flush_req  input  1  request to emit the partial beat; level-sampled in RUN.
REQ-011 flush_done  output  1  one-cycle pulse when the flush completes.
REQ-012 out_valid  output  1  beat available.
REQ-013 out_data  output  BEAT_WIDTH  output beat.
REQ-014 out_last  output  1  final beat of a flush.
REQ-015 out_ready  input  1  downstream accepts the beat.
REQ-016 fill_bits  output  FILL_W  current buffered bit count F.
REQ-017 beat_cnt  output  32  beats emitted since reset; wraps at 2^32.

Function
REQ-018 SHALL issue an elaboration $error if IN_WIDTH < 1 or IN_WIDTH > BEAT_WIDTH.
REQ-019 SHALL hold a 2*BEAT_WIDTH-bit residual buffer and fill count F; buffered bits occupy buf[F-1:0], oldest at bit 0.
REQ-020 in fire = in_valid && in_ready; out fire = out_valid && out_ready.
REQ-021 State machine SHALL have states RUN, FLUSH, DONE.
REQ-022 RUN: in_ready = (F <= 2*BEAT_WIDTH - IN_WIDTH), from registered F only, with no combinational path from out_ready.
REQ-023 RUN: out_valid = (F >= BEAT_WIDTH); out_data = buf[BEAT_WIDTH-1:0]; out_last = 0.
REQ-024 On out fire, buffer SHALL shift right by BEAT_WIDTH and F SHALL decrease by BEAT_WIDTH; beat_cnt SHALL increment.
REQ-025 On in fire, in_data[in_len-1:0] SHALL be written at offset F' (F after any same-cycle shift), F' += in_len; bits above in_len SHALL be masked.
REQ-026 Simultaneous in fire and out fire SHALL both take effect in one cycle: F_next = F - BEAT_WIDTH + in_len.
REQ-027 An in fire with in_len = 0 SHALL be accepted with no change to the buffer or F.
REQ-028 Latency: a word accepted at cycle t completing a beat SHALL appear on out_data at cycle t+1.
REQ-029 RUN with flush_req = 1 and no in fire that cycle SHALL go to FLUSH; if an in fire occurs, that word is absorbed first and FLUSH is entered next cycle if flush_req is still 1.
REQ-030 FLUSH: in_ready = 0; out_valid = (F > 0); out_data = buf[BEAT_WIDTH-1:0] with bits at and above min(F,BEAT_WIDTH) zeroed; out_last = (F <= BEAT_WIDTH).
REQ-031 FLUSH out fire with out_last = 1 SHALL set F = 0, clear the buffer and go to DONE; otherwise it follows REQ-024.
REQ-032 FLUSH with F = 0 SHALL go to DONE without emitting a beat.
REQ-033 DONE SHALL last exactly one cycle with flush_done = 1, in_ready = 0, out_valid = 0, then return to RUN.
REQ-034 out_data and out_valid SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-035 F SHALL never exceed 2*BEAT_WIDTH.

Reset
REQ-036 rst SHALL force state RUN, F = 0, buffer = 0 and beat_cnt = 0.
REQ-037 During rst and on the first cycle after: in_ready = 1, out_valid = 0, out_last = 0, flush_done = 0, fill_bits = 0.
REQ-038 rst asserted mid-flush or mid-beat SHALL discard all buffered bits with no beat emitted.

Verification (IN_WIDTH=40, BEAT_WIDTH=64)
REQ-039 Two words, len 40 (all 1s then all 0s), out_ready=1 -> one beat 0x000000FFFFFFFFFF, F=16, beat_cnt=1.
REQ-040 F=16 then flush_req -> beat with bits 63:16 zero, out_last=1; next cycle flush_done=1; then RUN with F=0.
REQ-041 out_ready=0, words of len 40 -> in_ready=1 at F=0,40,80; F=120 -> in_ready=0; out_data stable; out_ready=1 -> F=56, in_ready=1.
REQ-042 F=64 with simultaneous in fire (len 40) and out fire -> F=40, beat = first 64 bits, new word at buf[39:0].
REQ-043 flush_req at F=0 -> no out_valid; flush_done pulses exactly 1 cycle, two cycles after the request.
REQ-044 rst asserted at F=100 while in FLUSH -> next cycle F=0, out_valid=0, beat_cnt=0, state RUN.
